// File: rtl/buffet_pkg.sv
// Shared widths, payload structs and helpers for the buffet controller family.
package buffet_pkg;

  localparam int unsigned BUF_DATA_W  = 32;
  localparam int unsigned BUF_ADDR_W  = 8;
  localparam int unsigned BUF_SB_SIZE = 4;

  typedef struct packed {
    logic                  valid;
    logic [BUF_ADDR_W-1:0] addr;
  } sb_entry_t;

  typedef struct packed {
    logic                  valid;
    logic [BUF_ADDR_W-1:0] offset;
    logic [BUF_ADDR_W-1:0] addr;
    logic                  will_update;
  } read_stage_t;

  function automatic int unsigned buf_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/buffet_scoreboard.sv
// Read-will-update CAM: tracks absolute addresses with an update still pending.
module buffet_scoreboard
  import buffet_pkg::*;
#(
  parameter int unsigned SB_SIZE    = BUF_SB_SIZE,
  parameter int unsigned ADDR_WIDTH = BUF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  ins_en,
  input  logic [ADDR_WIDTH-1:0] ins_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit_c,
  output logic                  clr_hit_c,
  output logic                  full_c,
  output logic                  empty_c
);

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
  } entry_t;

  entry_t [SB_SIZE-1:0] ent;
  logic   [SB_SIZE-1:0] ins_sel;
  logic   [SB_SIZE-1:0] clr_sel;
  logic                 ins_found;
  logic                 clr_found;

  // Priority encode lowest free slot (insert) and lowest matching slot (clear).
  always_comb begin
    lookup_hit_c = 1'b0;
    full_c       = 1'b1;
    empty_c      = 1'b1;
    ins_sel      = '0;
    clr_sel      = '0;
    ins_found    = 1'b0;
    clr_found    = 1'b0;
    for (int i = 0; i < int'(SB_SIZE); i++) begin
      if (ent[i].valid) begin
        empty_c = 1'b0;
        if (ent[i].addr == lookup_addr) lookup_hit_c = 1'b1;
        if (ent[i].addr == clr_addr && !clr_found) begin
          clr_sel[i] = 1'b1;
          clr_found  = 1'b1;
        end
      end else begin
        full_c = 1'b0;
        if (!ins_found) begin
          ins_sel[i] = 1'b1;
          ins_found  = 1'b1;
        end
      end
    end
    clr_hit_c = clr_found;
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      ent <= '0;
    end else begin
      for (int i = 0; i < int'(SB_SIZE); i++) begin
        if (clr_en && clr_sel[i]) ent[i].valid <= 1'b0;
        else if (ins_en && ins_sel[i]) ent[i] <= entry_t'{valid: 1'b1, addr: ins_addr};
      end
    end
  end

endmodule

// File: rtl/buffet_ctrl_sb.sv
// Circular buffet controller with RAW scoreboard, credit output and sticky error.
module buffet_ctrl_sb
  import buffet_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BUF_DATA_W,
  parameter int unsigned ADDR_WIDTH = BUF_ADDR_W,
  parameter int unsigned SB_SIZE    = BUF_SB_SIZE
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] fill_data_i,
  input  logic                  fill_valid_i,
  output logic                  fill_ready_o,
  input  logic [ADDR_WIDTH-1:0] read_idx_i,
  input  logic                  read_will_update_i,
  input  logic                  read_valid_i,
  output logic                  read_ready_o,
  input  logic [ADDR_WIDTH-1:0] update_idx_i,
  input  logic [DATA_WIDTH-1:0] update_data_i,
  input  logic                  update_valid_i,
  output logic                  update_ready_o,
  input  logic [ADDR_WIDTH:0]   shrink_num_i,
  input  logic                  shrink_valid_i,
  output logic                  shrink_ready_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [ADDR_WIDTH:0]   credit_o,
  output logic                  err_o
);

  localparam int unsigned   DEPTH   = buf_depth(ADDR_WIDTH);
  localparam int unsigned   CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  will_update;
  } stage_t;

  logic [ADDR_WIDTH-1:0] head, tail;
  logic [CW-1:0]         count, count_next;
  stage_t                stage;
  logic [ADDR_WIDTH-1:0] upd_abs;
  logic fill_fire, upd_fire, read_fire, shrink_fire, shrink_ok, shrink_bad, dispatch;
  logic sb_hit, sb_clr_hit, sb_full, sb_empty;

  assign fill_ready_o   = ~reset_i & (count < DEPTH_C) & ~update_valid_i;
  assign update_ready_o = ~reset_i;
  assign read_ready_o   = ~reset_i & (~stage.valid | dispatch);
  assign shrink_ready_o = ~reset_i & ~stage.valid & sb_empty;

  assign fill_fire   = fill_valid_i & fill_ready_o;
  assign upd_fire    = update_valid_i & update_ready_o;
  assign read_fire   = read_valid_i & read_ready_o;
  assign shrink_fire = shrink_valid_i & shrink_ready_o;
  assign shrink_ok   = shrink_fire & (shrink_num_i <= count);
  assign shrink_bad  = shrink_fire & ~shrink_ok;
  assign upd_abs     = tail + update_idx_i;

  // Staged read leaves once its data exists, no pending update covers it, and a slot is free.
  assign dispatch = stage.valid & ({1'b0, stage.offset} < count) & ~sb_hit
                  & (~stage.will_update | ~sb_full);

  assign count_next = count + CW'(fill_fire) - (shrink_ok ? shrink_num_i : '0);

  buffet_scoreboard #(
    .SB_SIZE    (SB_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sb (
    .clk          (clk),
    .reset_i      (reset_i),
    .ins_en       (dispatch & stage.will_update),
    .ins_addr     (stage.addr),
    .clr_en       (upd_fire),
    .clr_addr     (upd_abs),
    .lookup_addr  (stage.addr),
    .lookup_hit_c (sb_hit),
    .clr_hit_c    (sb_clr_hit),
    .full_c       (sb_full),
    .empty_c      (sb_empty)
  );

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      credit_o  <= DEPTH_C;
      stage     <= '0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      rd_en_o   <= 1'b0;
      rd_addr_o <= '0;
      err_o     <= 1'b0;
    end else begin
      if (fill_fire) head <= head + ADDR_WIDTH'(1);
      if (shrink_ok) tail <= tail + shrink_num_i[ADDR_WIDTH-1:0];
      count    <= count_next;
      credit_o <= DEPTH_C - count_next;

      // Update owns the write port; fill is already held off by its ready.
      wr_en_o <= upd_fire | fill_fire;
      if (upd_fire) begin
        wr_addr_o <= upd_abs;
        wr_data_o <= update_data_i;
      end else if (fill_fire) begin
        wr_addr_o <= head;
        wr_data_o <= fill_data_i;
      end

      rd_en_o <= dispatch;
      if (dispatch) rd_addr_o <= stage.addr;

      if (read_fire) begin
        stage <= stage_t'{valid: 1'b1, offset: read_idx_i,
                          addr: tail + read_idx_i, will_update: read_will_update_i};
      end else if (dispatch) begin
        stage.valid <= 1'b0;
      end

      err_o <= err_o | shrink_bad | (upd_fire & ~sb_clr_hit);
    end
  end

endmodule

// File: tb/tb_buffet_ctrl_sb.sv
// Directed bench for buffet_ctrl_sb (DEPTH=8) with a memory-port scoreboard.
module tb_buffet_ctrl_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [DW-1:0] fill_data_i;
  logic          fill_valid_i, fill_ready_o;
  logic [AW-1:0] read_idx_i;
  logic          read_will_update_i, read_valid_i, read_ready_o;
  logic [AW-1:0] update_idx_i;
  logic [DW-1:0] update_data_i;
  logic          update_valid_i, update_ready_o;
  logic [AW:0]   shrink_num_i;
  logic          shrink_valid_i, shrink_ready_o;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [AW:0]   credit_o;
  logic          err_o;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wexp_t;

  wexp_t         wq[$];
  logic [AW-1:0] rq[$];
  int            checks   = 0;
  int            failures = 0;

  buffet_ctrl_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SB_SIZE(4)) dut (
    .clk(clk), .reset_i(reset_i),
    .fill_data_i(fill_data_i), .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o),
    .read_idx_i(read_idx_i), .read_will_update_i(read_will_update_i),
    .read_valid_i(read_valid_i), .read_ready_o(read_ready_o),
    .update_idx_i(update_idx_i), .update_data_i(update_data_i),
    .update_valid_i(update_valid_i), .update_ready_o(update_ready_o),
    .shrink_num_i(shrink_num_i), .shrink_valid_i(shrink_valid_i), .shrink_ready_o(shrink_ready_o),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .credit_o(credit_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [DW-1:0] d, input logic [AW-1:0] a);
    fill_valid_i = 1'b1;
    fill_data_i  = d;
    #1 chk("fill_ready", fill_ready_o, 1);
    wq.push_back(wexp_t'{a, d});
    tick();
    fill_valid_i = 1'b0;
  endtask

  task automatic shrink(input logic [AW:0] n);
    shrink_valid_i = 1'b1;
    shrink_num_i   = n;
    #1 chk("shrink_ready", shrink_ready_o, 1);
    tick();
    shrink_valid_i = 1'b0;
  endtask

  task automatic read(input logic [AW-1:0] off, input logic wu);
    read_valid_i       = 1'b1;
    read_idx_i         = off;
    read_will_update_i = wu;
    #1 chk("read_ready", read_ready_o, 1);
    tick();
    read_valid_i = 1'b0;
  endtask

  // Monitor: every memory-port event must match the head of its expectation queue.
  always @(negedge clk) begin
    wexp_t e;
    logic [AW-1:0] ra;
    if (wr_en_o) begin
      checks++;
      if (wq.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: got addr %0d data %0h expected no write", wr_addr_o, wr_data_o);
      end else begin
        e = wq.pop_front();
        if (wr_addr_o !== e.addr || wr_data_o !== e.data) begin
          failures++;
          $display("FAIL wr_port: got addr %0d data %0h expected addr %0d data %0h",
                   wr_addr_o, wr_data_o, e.addr, e.data);
        end
      end
    end
    if (rd_en_o) begin
      checks++;
      if (rq.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got addr %0d expected no read", rd_addr_o);
      end else begin
        ra = rq.pop_front();
        if (rd_addr_o !== ra) begin
          failures++;
          $display("FAIL rd_port: got addr %0d expected %0d", rd_addr_o, ra);
        end
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    fill_data_i = '0; fill_valid_i = 1'b0;
    read_idx_i = '0; read_will_update_i = 1'b0; read_valid_i = 1'b0;
    update_idx_i = '0; update_data_i = '0; update_valid_i = 1'b0;
    shrink_num_i = '0; shrink_valid_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_fill_ready", fill_ready_o, 0);
    chk("rst_read_ready", read_ready_o, 0);
    chk("rst_update_ready", update_ready_o, 0);
    chk("rst_shrink_ready", shrink_ready_o, 0);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_rd_en", rd_en_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_credit", credit_o, 8);
    reset_i = 1'b0;
    #1;
    chk("post_rst_fill_ready", fill_ready_o, 1);
    chk("post_rst_read_ready", read_ready_o, 1);
    chk("post_rst_update_ready", update_ready_o, 1);
    chk("post_rst_shrink_ready", shrink_ready_o, 1);
    tick();

    // Fill to full; ninth fill must be held.
    for (int i = 0; i < 8; i++) fill(32'h10 + 32'(i), 3'(i));
    chk("full_credit", credit_o, 0);
    chk("full_fill_ready", fill_ready_o, 0);
    fill_valid_i = 1'b1;
    fill_data_i  = 32'h99;
    repeat (3) begin
      tick();
      chk("ninth_fill_held", fill_ready_o, 0);
    end
    fill_valid_i = 1'b0;
    shrink(4'd8);
    chk("empty_credit", credit_o, 8);

    // Read beyond occupancy waits for data.
    fill(32'h20, 3'd0);
    fill(32'h21, 3'd1);
    read(3'd3, 1'b0);
    repeat (3) begin
      tick();
      chk("war_stall_ready", read_ready_o, 0);
    end
    rq.push_back(3'd3);
    fill(32'h22, 3'd2);
    fill(32'h23, 3'd3);
    chk("war_rd_not_yet", rd_en_o, 0);
    tick();
    chk("war_rd_en", rd_en_o, 1);
    chk("war_rd_addr", rd_addr_o, 3);

    // Read-will-update then dependent read: second waits for the update.
    rq.push_back(3'd1);
    rq.push_back(3'd1);
    read_valid_i = 1'b1; read_idx_i = 3'd1; read_will_update_i = 1'b1;
    #1 chk("rwu_ready", read_ready_o, 1);
    tick();
    read_will_update_i = 1'b0;
    #1 chk("b2b_ready", read_ready_o, 1);
    tick();
    read_valid_i = 1'b0;
    chk("rwu_rd_en", rd_en_o, 1);
    tick();
    chk("raw_stall_ready", read_ready_o, 0);
    chk("raw_shrink_blocked", shrink_ready_o, 0);
    tick();
    chk("raw_stall_rd", rd_en_o, 0);
    wq.push_back(wexp_t'{3'd1, 32'hAB});
    update_valid_i = 1'b1; update_idx_i = 3'd1; update_data_i = 32'hAB;
    #1 chk("upd_blocks_fill", fill_ready_o, 0);
    tick();
    update_valid_i = 1'b0;
    chk("upd_wr_en", wr_en_o, 1);
    chk("raw_rd_held", rd_en_o, 0);
    tick();
    chk("raw_rd_en", rd_en_o, 1);
    chk("upd_match_no_err", err_o, 0);

    // Walk tail to 6 with count 5, then shrink 3 across the wrap.
    shrink(4'd4);
    chk("shrink4_credit", credit_o, 8);
    fill(32'h40, 3'd4);
    fill(32'h41, 3'd5);
    shrink(4'd2);
    for (int i = 0; i < 5; i++) fill(32'h42 + 32'(i), 3'(6 + i));
    chk("count5_credit", credit_o, 3);
    shrink(4'd3);
    chk("wrap_credit", credit_o, 6);
    rq.push_back(3'd1);
    read(3'd0, 1'b0);
    tick();
    chk("wrap_rd_en", rd_en_o, 1);
    chk("wrap_rd_addr", rd_addr_o, 1);

    // Update with no pending read-will-update still writes and flags error.
    wq.push_back(wexp_t'{3'd1, 32'h55});
    chk("err_clear_before", err_o, 0);
    update_valid_i = 1'b1; update_idx_i = 3'd0; update_data_i = 32'h55;
    tick();
    update_valid_i = 1'b0;
    chk("nomatch_wr_en", wr_en_o, 1);
    chk("nomatch_err", err_o, 1);

    // Update and fill together: update first, fill one cycle later.
    wq.push_back(wexp_t'{3'd1, 32'h66});
    wq.push_back(wexp_t'{3'd3, 32'h77});
    update_valid_i = 1'b1; update_idx_i = 3'd0; update_data_i = 32'h66;
    fill_valid_i = 1'b1; fill_data_i = 32'h77;
    #1 chk("coll_fill_ready", fill_ready_o, 0);
    tick();
    update_valid_i = 1'b0;
    chk("coll_upd_addr", wr_addr_o, 1);
    #1 chk("coll_fill_ready_after", fill_ready_o, 1);
    tick();
    fill_valid_i = 1'b0;
    chk("coll_fill_addr", wr_addr_o, 3);
    tick();
    chk("coll_credit", credit_o, 5);
    chk("err_sticky", err_o, 1);

    // Reset while a read is stalled drops it.
    read(3'd7, 1'b0);
    repeat (2) tick();
    chk("stall7_ready", read_ready_o, 0);
    reset_i = 1'b1;
    #1;
    chk("midrst_credit", credit_o, 8);
    chk("midrst_err", err_o, 0);
    chk("midrst_read_ready", read_ready_o, 0);
    tick();
    reset_i = 1'b0;
    #1 chk("after_midrst_read_ready", read_ready_o, 1);
    for (int i = 0; i < 8; i++) fill(32'h30 + 32'(i), 3'(i));
    repeat (4) begin
      tick();
      chk("dropped_read_silent", rd_en_o, 0);
    end

    // Oversized shrink is ignored and flags a sticky error.
    shrink(4'd4);
    chk("pre_bad_credit", credit_o, 4);
    shrink(4'd5);
    chk("bad_shrink_err", err_o, 1);
    chk("bad_shrink_credit", credit_o, 4);
    repeat (3) tick();
    chk("bad_shrink_sticky", err_o, 1);

    repeat (3) tick();
    chk("wq_drained", 64'(wq.size()), 0);
    chk("rq_drained", 64'(rq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
